hash_message_build: RTL and testbench
=====================================

HASH_MESSAGE_BUILD -- requirements
Module: hash_message_build

Interface
REQ-001 SHALL have no parameters; all widths are fixed for SHA-256.
REQ-002 clk  input  1  single clock; all state is updated on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 sync_rst  input  1  synchronous, localised reset; same effect as rst, applied at the clk edge.
REQ-005 data_in  input  32  message word, big-endian; first byte is in [31:24].
REQ-006 data_in_bytes  input  3  valid bytes in the word: 4 on non-last words, 0..4 on the last word.
REQ-007 data_in_last  input  1  marks the final word of the message.
REQ-008 data_in_valid  input  1  the input word is valid.
REQ-009 data_in_ready  output  1  the block accepts a word this cycle.
REQ-010 data_out  output  512  padded 512-bit block; word 0 is in [511:480].
REQ-011 data_out_last  output  1  marks the final block of the message; feeds the compression stage's data_in_last.
REQ-012 data_out_valid  output  1  data_out holds a block.
REQ-013 data_out_ready  input  1  the downstream compression stage accepts the block.

Function
REQ-014 SHALL accept a word only on data_in_valid && data_in_ready, and SHALL write it into buffer word index w (0..15); w increments per accepted word.
REQ-015 data_in_ready SHALL be 1 only when state==COLLECT and data_out_valid==0; input stalls while a block awaits handshake.
REQ-016 SHALL keep a 64-bit message bit-length counter L, incremented by 8*data_in_bytes per accepted word and wrapping modulo 2^64.
REQ-017 States: COLLECT, EXTRA; reset enters COLLECT with w=0 and L=0.
REQ-018 COLLECT, non-last word accepted at w=15 SHALL drive the following on the next cycle:
- data_out = the buffer, data_out_last=0, data_out_valid=1;
- w=0; state stays COLLECT.
REQ-019 COLLECT, last word accepted at index i with b bytes:
- bytes >= b of word i SHALL be zeroed;
- if b<4, 0x80 goes at byte b of word i and p=i; if b==4, p=i+1;
- all words above p SHALL be zero.
REQ-020 If p<=13, the block output on the next cycle SHALL have:
- words 14/15 = L[63:32]/L[31:0], with L including the final word;
- data_out_last=1; w=0, L=0; state COLLECT.
REQ-021 If p is 14 or 15, SHALL output the padded block with data_out_last=0 and go to EXTRA.
REQ-022 If p==16 (i=15, b=4), SHALL output the data block unmodified with data_out_last=0 and go to EXTRA, recording that 0x80 is still owed.
REQ-023 EXTRA SHALL wait for the pending block's handshake, then on the next cycle output a block of zeros with:
- word 0 = 0x80000000 if 0x80 is owed;
- words 14/15 = length;
- data_out_last=1.
After that EXTRA SHALL clear w and L and return to COLLECT.
REQ-024 data_out_valid SHALL stay 1, with data_out and data_out_last stable, until data_out_ready is sampled high; it SHALL clear the cycle after the handshake unless a new block is loaded that cycle.
REQ-025 Latency: a block SHALL be valid 1 cycle after its completing word is accepted; the EXTRA block SHALL be valid 1 cycle after the prior block's handshake.
REQ-026 data_in_bytes of 0 on a non-last word, or anything other than 4 on a non-last word, is illegal; the block SHALL treat it as 4.
REQ-027 A last word with b=0 (including an empty message) SHALL contribute no bytes; 0x80 goes at byte 0 of that word.

Reset
REQ-028 On rst (asynchronous) or sync_rst, SHALL set the following, discarding any partial message or pending block:
- state=COLLECT, w=0, L=0, buffer=0;
- data_out=0, data_out_last=0, data_out_valid=0.
REQ-029 data_in_ready SHALL be 0 while reset is asserted and 1 on the first cycle after release.

Structure
REQ-030 The shared hashing package SHALL hold the following; state encodings stay local to the module:
- block width 512, word width 32, length width 64;
- the padding byte 8'h80.
REQ-031 SHALL be one module with no sub-modules; the packing of padding and length is a package function.

Verification
REQ-032 "abc":
- stimulus: one word 0x61626300, bytes=3, last;
- response: one block with word0=0x61626380, words 1..14=0, word15=0x00000018, last=1;
- through the compression stage the digest is 0xba7816bf...f20015ad.
REQ-033 Empty message:
- stimulus: one word with bytes=0, last;
- response: word0=0x80000000, all other words 0, last=1.
REQ-034 56-byte message:
- stimulus: 14 words, last word bytes=4;
- response: block 1 has word14=0x80000000, word15=0, last=0;
- block 2 is zeros, word15=0x000001C0, last=1.
REQ-035 64-byte message:
- stimulus: 16 full words;
- response: data block with last=0;
- then word0=0x80000000, word15=0x00000200, last=1.
REQ-036 Backpressure and reset:
- hold data_out_ready=0 for 10 cycles: data_out stays stable and data_in_ready=0;
- assert rst mid-message, then send "abc": output matches REQ-032.

Source files
------------

// File: rtl/hash_message_build_pkg.sv
// Shared SHA-256 message-building constants and the padding/length packing helpers.
package hash_message_build_pkg;

  localparam int BLOCK_W = 512;
  localparam int WORD_W  = 32;
  localparam int LEN_W   = 64;
  localparam logic [7:0] PAD_BYTE = 8'h80;

  // Pad the final data word at idx (nbytes valid), clear everything above it and,
  // when the padding byte lands in word 13 or earlier, append the bit length.
  function automatic logic [BLOCK_W-1:0] pad_block(input logic [BLOCK_W-1:0] blk,
                                                   input logic [3:0] idx,
                                                   input logic [2:0] nbytes,
                                                   input logic [LEN_W-1:0] len);
    logic [BLOCK_W-1:0] r;
    logic [WORD_W-1:0]  wd;
    int p;
    r = blk;
    p = (nbytes == 3'd4) ? int'(idx) + 1 : int'(idx);
    for (int k = 0; k < 16; k++) begin
      wd = blk[BLOCK_W-1-WORD_W*k -: WORD_W];
      if (k == int'(idx)) begin
        for (int j = 0; j < 4; j++) begin
          if (j >= int'(nbytes)) wd[31-8*j -: 8] = (j == int'(nbytes)) ? PAD_BYTE : 8'h00;
        end
      end else if (k > int'(idx)) begin
        wd = (k == p) ? {PAD_BYTE, 24'h0} : '0;
      end
      r[BLOCK_W-1-WORD_W*k -: WORD_W] = wd;
    end
    if (p <= 13) r[LEN_W-1:0] = len;
    return r;
  endfunction

  function automatic logic [BLOCK_W-1:0] len_block(input logic owed,
                                                   input logic [LEN_W-1:0] len);
    logic [BLOCK_W-1:0] r;
    r = '0;
    if (owed) r[BLOCK_W-1 -: WORD_W] = {PAD_BYTE, 24'h0};
    r[LEN_W-1:0] = len;
    return r;
  endfunction

endpackage

// File: rtl/hash_message_build.sv
// Collects 32-bit message words into 512-bit SHA-256 blocks and applies the
// standard 0x80 / zero / 64-bit-length padding, spilling into an extra block when needed.
module hash_message_build
  import hash_message_build_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               sync_rst,
  input  logic [WORD_W-1:0]  data_in,
  input  logic [2:0]         data_in_bytes,
  input  logic               data_in_last,
  input  logic               data_in_valid,
  output logic               data_in_ready,
  output logic [BLOCK_W-1:0] data_out,
  output logic               data_out_last,
  output logic               data_out_valid,
  input  logic               data_out_ready
);

  typedef enum logic {COLLECT, EXTRA} state_t;

  state_t             state_q, state_d;
  logic [3:0]         w_q, w_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [BLOCK_W-1:0] buf_q, buf_d;
  logic [BLOCK_W-1:0] dout_q, dout_d;
  logic               last_q, last_d;
  logic               valid_q, valid_d;
  logic               owed_q, owed_d;

  logic               accept, hs;
  logic [2:0]         bytes_eff;
  logic [4:0]         p_idx;
  logic [LEN_W-1:0]   len_new;
  logic [BLOCK_W-1:0] blk_in;

  assign data_in_ready  = (state_q == COLLECT) && !valid_q && !rst && !sync_rst;
  assign data_out       = dout_q;
  assign data_out_last  = last_q;
  assign data_out_valid = valid_q;

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    len_d   = len_q;
    buf_d   = buf_q;
    dout_d  = dout_q;
    last_d  = last_q;
    valid_d = valid_q;
    owed_d  = owed_q;

    accept = data_in_valid && data_in_ready;
    hs     = valid_q && data_out_ready;
    // Non-last words always carry four bytes; oversize counts saturate at four.
    bytes_eff = (!data_in_last || data_in_bytes > 3'd4) ? 3'd4 : data_in_bytes;
    p_idx     = (bytes_eff == 3'd4) ? {1'b0, w_q} + 5'd1 : {1'b0, w_q};
    len_new   = len_q + {58'h0, bytes_eff, 3'b000};
    blk_in    = buf_q;
    blk_in[BLOCK_W-1-WORD_W*int'(w_q) -: WORD_W] = data_in;

    if (hs) valid_d = 1'b0;

    case (state_q)
      COLLECT: begin
        if (accept) begin
          buf_d = blk_in;
          len_d = len_new;
          if (data_in_last) begin
            dout_d  = pad_block(blk_in, w_q, bytes_eff, len_new);
            valid_d = 1'b1;
            w_d     = 4'd0;
            if (p_idx <= 5'd13) begin
              last_d = 1'b1;
              len_d  = '0;
            end else begin
              last_d  = 1'b0;
              owed_d  = (p_idx == 5'd16);
              state_d = EXTRA;
            end
          end else if (w_q == 4'd15) begin
            dout_d  = blk_in;
            last_d  = 1'b0;
            valid_d = 1'b1;
            w_d     = 4'd0;
          end else begin
            w_d = w_q + 4'd1;
          end
        end
      end
      EXTRA: begin
        if (hs) begin
          dout_d  = len_block(owed_q, len_q);
          last_d  = 1'b1;
          valid_d = 1'b1;
          w_d     = 4'd0;
          len_d   = '0;
          owed_d  = 1'b0;
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= COLLECT;
      w_q     <= '0;
      len_q   <= '0;
      buf_q   <= '0;
      dout_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      owed_q  <= 1'b0;
    end else if (sync_rst) begin
      state_q <= COLLECT;
      w_q     <= '0;
      len_q   <= '0;
      buf_q   <= '0;
      dout_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      owed_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      len_q   <= len_d;
      buf_q   <= buf_d;
      dout_q  <= dout_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      owed_q  <= owed_d;
    end
  end

endmodule

// File: tb/tb_hash_message_build.sv
// Randomized bench for hash_message_build against a byte-level SHA-256 padding model.
module tb_hash_message_build;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sync_rst = 1'b0;
  logic [31:0]  data_in = '0;
  logic [2:0]   data_in_bytes = '0;
  logic         data_in_last = 1'b0;
  logic         data_in_valid = 1'b0;
  logic         data_in_ready;
  logic [511:0] data_out;
  logic         data_out_last;
  logic         data_out_valid;
  logic         data_out_ready = 1'b0;

  int total = 0;
  int bad = 0;
  logic hold_rdy = 1'b0;

  logic [511:0] got_data[$];
  logic         got_last[$];
  logic [511:0] exp_data[$];
  logic         exp_last[$];

  hash_message_build dut (
    .clk(clk), .rst(rst), .sync_rst(sync_rst),
    .data_in(data_in), .data_in_bytes(data_in_bytes), .data_in_last(data_in_last),
    .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
    .data_out(data_out), .data_out_last(data_out_last), .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      data_out_ready = hold_rdy ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && !sync_rst && data_out_valid && data_out_ready) begin
        got_data.push_back(data_out);
        got_last.push_back(data_out_last);
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Standard SHA-256 padding on the byte stream: msg, 0x80, zeros, 64-bit big-endian bit count.
  function automatic void build_expected(input logic [31:0] words[$], input int last_b);
    logic [7:0]   q[$];
    logic [63:0]  bits;
    logic [511:0] b;
    int n;
    n = words.size();
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < ((i == n - 1) ? last_b : 4); j++) q.push_back(words[i][31-8*j -: 8]);
    end
    bits = 64'(q.size()) * 64'd8;
    q.push_back(8'h80);
    while (q.size() % 64 != 56) q.push_back(8'h00);
    for (int k = 7; k >= 0; k--) q.push_back(bits[8*k+7 -: 8]);
    exp_data.delete();
    exp_last.delete();
    for (int base = 0; base < q.size(); base += 64) begin
      for (int j = 0; j < 64; j++) b[511-8*j -: 8] = q[base+j];
      exp_data.push_back(b);
      exp_last.push_back(base + 64 == q.size());
    end
  endfunction

  // Entered and left at posedge+1.
  task automatic drive_word(input logic [31:0] d, input logic [2:0] nb, input logic last);
    int n;
    data_in = d;
    data_in_bytes = nb;
    data_in_last = last;
    data_in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (data_in_ready) break;
      n++;
      if (n > 2000) begin
        total++; bad++;
        $display("FAIL accept_timeout: data_in_ready=%0b required 1", data_in_ready);
        break;
      end
    end
    @(posedge clk);
    #1;
    data_in_valid = 1'b0;
    data_in_last = 1'b0;
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_msg(input string name, input logic [31:0] words[$], input int last_b,
                         input logic illegal);
    logic [2:0] nb;
    int c;
    got_data.delete();
    got_last.delete();
    build_expected(words, last_b);
    for (int i = 0; i < words.size(); i++) begin
      if (i == words.size() - 1) nb = 3'(last_b);
      else if (illegal && $urandom_range(0, 3) == 0) nb = 3'($urandom_range(0, 7));
      else nb = 3'd4;
      drive_word(words[i], nb, i == words.size() - 1);
    end
    c = 0;
    while (got_data.size() < exp_data.size() && c < 2000) begin
      @(negedge clk);
      c++;
    end
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1;
    total++;
    if (got_data.size() !== exp_data.size()) begin
      bad++;
      $display("FAIL %s block_count: got %0d required %0d", name, got_data.size(), exp_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      total++;
      if (got_data[i] !== exp_data[i]) begin
        bad++;
        $display("FAIL %s block%0d data: got %h required %h", name, i, got_data[i], exp_data[i]);
      end
      total++;
      if (got_last[i] !== exp_last[i]) begin
        bad++;
        $display("FAIL %s block%0d last: got %0b required %0b", name, i, got_last[i], exp_last[i]);
      end
    end
  endtask

  task automatic rand_words(input int n, output logic [31:0] q[$]);
    q.delete();
    for (int i = 0; i < n; i++) q.push_back($urandom);
  endtask

  task automatic check_idle_outputs(input string name, input logic want_ready);
    total++;
    if (data_out_valid !== 1'b0 || data_out_last !== 1'b0 || data_out !== '0) begin
      bad++;
      $display("FAIL %s outputs: valid=%0b last=%0b data=%h required all zero", name,
               data_out_valid, data_out_last, data_out);
    end
    total++;
    if (data_in_ready !== want_ready) begin
      bad++;
      $display("FAIL %s data_in_ready: got %0b required %0b", name, data_in_ready, want_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("reset_asserted", 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset_release", 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic test_abc();
    logic [31:0] w[$];
    w.push_back(32'h61626300);
    run_msg("abc", w, 3, 1'b0);
    if (got_data.size() > 0) begin
      total++;
      if (got_data[0] !== {32'h61626380, 448'h0, 32'h00000018}) begin
        bad++;
        $display("FAIL abc_const: got %h", got_data[0]);
      end
    end
  endtask

  task automatic test_empty();
    logic [31:0] w[$];
    w.push_back($urandom);
    run_msg("empty", w, 0, 1'b0);
    if (got_data.size() > 0) begin
      total++;
      if (got_data[0] !== {32'h80000000, 480'h0}) begin
        bad++;
        $display("FAIL empty_const: got %h", got_data[0]);
      end
    end
  endtask

  task automatic test_56_bytes();
    logic [31:0] w[$];
    rand_words(14, w);
    run_msg("bytes56", w, 4, 1'b0);
    if (got_data.size() > 1) begin
      total++;
      if (got_data[0][63:0] !== 64'h80000000_00000000) begin
        bad++;
        $display("FAIL bytes56_w14w15: got %h required 8000000000000000", got_data[0][63:0]);
      end
      total++;
      if (got_data[1] !== {480'h0, 32'h000001C0}) begin
        bad++;
        $display("FAIL bytes56_len_block: got %h", got_data[1]);
      end
    end
  endtask

  task automatic test_64_bytes();
    logic [31:0] w[$];
    rand_words(16, w);
    run_msg("bytes64", w, 4, 1'b0);
    if (got_data.size() > 1) begin
      total++;
      if (got_data[1] !== {32'h80000000, 448'h0, 32'h00000200}) begin
        bad++;
        $display("FAIL bytes64_len_block: got %h", got_data[1]);
      end
    end
  endtask

  task automatic test_boundaries();
    logic [31:0] w[$];
    int nw[6] = '{14, 14, 15, 16, 16, 17};
    int lb[6] = '{3, 4, 2, 0, 4, 0};
    for (int i = 0; i < 6; i++) begin
      rand_words(nw[i], w);
      run_msg($sformatf("bound%0d", i), w, lb[i], 1'b0);
    end
  endtask

  task automatic test_random();
    logic [31:0] w[$];
    for (int i = 0; i < 25; i++) begin
      rand_words($urandom_range(1, 40), w);
      run_msg($sformatf("rand%0d", i), w, $urandom_range(0, 4), 1'b1);
    end
  endtask

  task automatic test_backpressure();
    logic [511:0] snap;
    int c;
    hold_rdy = 1'b1;
    data_out_ready = 1'b0;
    got_data.delete();
    got_last.delete();
    drive_word(32'h61626300, 3'd3, 1'b1);
    c = 0;
    while (!data_out_valid && c < 50) begin
      @(negedge clk);
      c++;
    end
    snap = data_out;
    total++;
    if (snap !== {32'h61626380, 448'h0, 32'h00000018}) begin
      bad++;
      $display("FAIL bp_block: got %h", snap);
    end
    data_in = 32'h12345678;
    data_in_bytes = 3'd4;
    data_in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (data_out !== snap || data_out_valid !== 1'b1 || data_out_last !== 1'b1) begin
        bad++;
        $display("FAIL bp_stable cycle%0d: valid=%0b last=%0b data=%h", i, data_out_valid,
                 data_out_last, data_out);
      end
      total++;
      if (data_in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_ready cycle%0d: got %0b required 0", i, data_in_ready);
      end
    end
    @(posedge clk);
    #1;
    data_in_valid = 1'b0;
    hold_rdy = 1'b0;
    c = 0;
    while (got_data.size() < 1 && c < 100) begin
      @(negedge clk);
      c++;
    end
    repeat (4) @(negedge clk);
    total++;
    if (got_data.size() !== 1 || got_data[0] !== snap) begin
      bad++;
      $display("FAIL bp_release: got %0d blocks required 1 matching block", got_data.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_async_reset_mid_msg();
    for (int i = 0; i < 5; i++) drive_word($urandom, 3'd4, 1'b0);
    test_reset();
    test_abc();
  endtask

  task automatic test_sync_reset_pending();
    int c;
    hold_rdy = 1'b1;
    data_out_ready = 1'b0;
    for (int i = 0; i < 16; i++) drive_word($urandom, 3'd4, 1'b0);
    c = 0;
    while (!data_out_valid && c < 50) begin
      @(negedge clk);
      c++;
    end
    total++;
    if (data_out_valid !== 1'b1) begin
      bad++;
      $display("FAIL sync_pending_valid: got %0b required 1", data_out_valid);
    end
    @(posedge clk);
    #1;
    sync_rst = 1'b1;
    @(negedge clk);
    total++;
    if (data_in_ready !== 1'b0) begin
      bad++;
      $display("FAIL sync_rst_ready: got %0b required 0", data_in_ready);
    end
    @(posedge clk);
    #1;
    sync_rst = 1'b0;
    hold_rdy = 1'b0;
    @(negedge clk);
    check_idle_outputs("sync_rst_release", 1'b1);
    @(posedge clk);
    #1;
    test_abc();
  endtask

  initial begin
    test_reset();
    test_abc();
    test_empty();
    test_56_bytes();
    test_64_bytes();
    test_boundaries();
    test_random();
    test_backpressure();
    test_async_reset_mid_msg();
    test_sync_reset_pending();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
